// File: rtl/page_pkg.sv
// Shared types and constants for the start-page control slice.
package page_pkg;

  // Menu state encoding
  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Page numbers consumed by the top-level page mux
  localparam logic [1:0] PAGE_START = 2'd0;
  localparam logic [1:0] PAGE_RUN   = 2'd1;

  localparam int MODE_W = 2;

  // Button vector layout used inside page_start_ctrl
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ENTER = 2;
  localparam int BTN_BACK  = 3;
  localparam int NUM_BTNS  = 4;

  // Step the mode index down, wrapping from 0 to the last mode
  function automatic logic [MODE_W-1:0] mode_prev(input logic [MODE_W-1:0] m,
                                                  input logic [MODE_W-1:0] last);
    return (m == '0) ? last : m - 1'b1;
  endfunction

  // Step the mode index up, wrapping from the last mode to 0
  function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] m,
                                                  input logic [MODE_W-1:0] last);
    return (m == last) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Single push-button conditioner: 2-flop synchronizer, debounce, one-shot press.
module btn_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_25MHz,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             level_prev_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Synchronize, accept a new level only after it has been stable long enough,
  // then emit a one-cycle pulse on each accepted rising edge.
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
      press_reg      <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Count only while a change is pending; any return to the accepted level restarts it.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
      level_prev_reg <= level_reg;
      press_reg      <= level_reg & ~level_prev_reg;
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/page_start_ctrl.sv
// Start-menu controller: conditions buttons, selects a mode, blinks the
// highlight and hands off to the run page with a one-cycle start strobe.
module page_start_ctrl
  import page_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int CONFIRM_TOGGLES = 6,
  parameter int NUM_MODES       = 2
) (
  input  logic              clk_25MHz,
  input  logic              rst,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_enter,
  input  logic              btn_back,
  output logic              opt,
  output logic [MODE_W-1:0] mode,
  output logic [1:0]        page,
  output logic              start_pulse
);

  localparam int BLINK_W = $clog2(BLINK_CYCLES);
  localparam int TOG_W   = $clog2(CONFIRM_TOGGLES + 1);

  localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] QUARTER_LAST = BLINK_W'(BLINK_CYCLES / 4 - 1);
  localparam logic [TOG_W-1:0]   TOG_FINAL    = TOG_W'(CONFIRM_TOGGLES);
  localparam logic [MODE_W-1:0]  MODE_LAST    = MODE_W'(NUM_MODES - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_level_unused;

  assign btn_raw = {btn_back, btn_enter, btn_right, btn_left};

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn_cond (
        .clk_25MHz(clk_25MHz),
        .rst      (rst),
        .raw      (btn_raw[gi]),
        .level    (btn_level_unused[gi]),
        .press    (btn_press[gi])
      );
    end
  endgenerate

  logic left_p, right_p, enter_p, back_p;
  assign left_p  = btn_press[BTN_LEFT];
  assign right_p = btn_press[BTN_RIGHT];
  assign enter_p = btn_press[BTN_ENTER];
  assign back_p  = btn_press[BTN_BACK];

  state_t              state_reg;
  logic                opt_reg;
  logic [MODE_W-1:0]   mode_reg;
  logic [1:0]          page_reg;
  logic                start_pulse_reg;
  logic [BLINK_W-1:0]  blink_cnt_reg;
  logic [TOG_W-1:0]    toggle_cnt_reg;
  logic [TOG_W-1:0]    toggle_cnt_next;

  assign toggle_cnt_next = toggle_cnt_reg + 1'b1;

  // Menu FSM with mode selection and blink timing; every output is a register.
  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_START;
      opt_reg         <= 1'b0;
      mode_reg        <= '0;
      page_reg        <= PAGE_START;
      start_pulse_reg <= 1'b0;
      blink_cnt_reg   <= '0;
      toggle_cnt_reg  <= '0;
    end else begin
      start_pulse_reg <= 1'b0;
      case (state_reg)
        ST_START: begin
          page_reg <= PAGE_START;
          if (enter_p) begin
            state_reg      <= ST_CONFIRM;
            opt_reg        <= 1'b1;
            blink_cnt_reg  <= '0;
            toggle_cnt_reg <= '0;
          end else if (left_p && !right_p) begin
            // Restart the blink with the highlight on so the new choice shows at once
            mode_reg      <= mode_prev(mode_reg, MODE_LAST);
            blink_cnt_reg <= '0;
            opt_reg       <= 1'b1;
          end else if (right_p && !left_p) begin
            mode_reg      <= mode_next(mode_reg, MODE_LAST);
            blink_cnt_reg <= '0;
            opt_reg       <= 1'b1;
          end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            opt_reg       <= ~opt_reg;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
          end
        end

        ST_CONFIRM: begin
          page_reg <= PAGE_START;
          // Abort takes precedence over a coincident final toggle
          if (back_p) begin
            state_reg     <= ST_START;
            opt_reg       <= 1'b1;
            blink_cnt_reg <= '0;
          end else if (blink_cnt_reg == QUARTER_LAST) begin
            blink_cnt_reg  <= '0;
            toggle_cnt_reg <= toggle_cnt_next;
            if (toggle_cnt_next == TOG_FINAL) begin
              state_reg       <= ST_RUN;
              start_pulse_reg <= 1'b1;
              opt_reg         <= 1'b0;
              page_reg        <= PAGE_RUN;
            end else begin
              opt_reg <= ~opt_reg;
            end
          end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
          end
        end

        ST_RUN: begin
          page_reg <= PAGE_RUN;
          opt_reg  <= 1'b0;
          if (back_p) begin
            state_reg     <= ST_START;
            opt_reg       <= 1'b1;
            blink_cnt_reg <= '0;
            page_reg      <= PAGE_START;
          end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg     <= ST_START;
          page_reg      <= PAGE_START;
          opt_reg       <= 1'b0;
          blink_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign opt         = opt_reg;
  assign mode        = mode_reg;
  assign page        = page_reg;
  assign start_pulse = start_pulse_reg;

endmodule

// File: tb/tb_page_start_ctrl.sv
// Testbench for page_start_ctrl: table of button patterns plus reset corner cases,
// with a per-cycle scoreboard of expected outputs.
module tb_page_start_ctrl;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int CT    = 6;
  localparam int NM    = 2;
  localparam int Q     = BLINK / 4;
  // Edge (counted from first sample) at which a press changes the outputs
  localparam int EFF   = DEB + 4;

  localparam logic [3:0] L = 4'b0001;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] E = 4'b0100;
  localparam logic [3:0] B = 4'b1000;
  localparam logic [3:0] N = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bl, br, be, bb;
  logic       opt;
  logic [1:0] mode;
  logic [1:0] page;
  logic       sp;

  always #20 clk = ~clk;

  page_start_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLINK),
    .CONFIRM_TOGGLES(CT),
    .NUM_MODES      (NM)
  ) dut (
    .clk_25MHz  (clk),
    .rst        (rst_n),
    .btn_left   (bl),
    .btn_right  (br),
    .btn_enter  (be),
    .btn_back   (bb),
    .opt        (opt),
    .mode       (mode),
    .page       (page),
    .start_pulse(sp)
  );

  typedef struct {
    logic [3:0] a;
    int         ha;
    logic [3:0] b;
    int         sb;
    int         hb;
    int         total;
    int         exp_mode;
    int         exp_page;
    string      name;
  } vec_t;

  typedef struct {
    logic       opt;
    logic [1:0] mode;
    logic [1:0] page;
    logic       sp;
    int         k;
  } exp_t;

  typedef enum int {M_START, M_CONFIRM, M_RUN} mstate_t;

  vec_t    tbl[12];
  exp_t    sbq[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  // Reference state
  int      k;
  mstate_t e_state;
  int      e_ref;
  logic    e_opt_ref;
  int      e_mode;

  task automatic drive(input logic [3:0] v);
    {bb, be, br, bl} = v;
  endtask

  function automatic void model_reset();
    k         = 0;
    e_state   = M_START;
    e_ref     = 0;
    e_opt_ref = 1'b0;
    e_mode    = 0;
  endfunction

  // Effect of press pulses landing on edge 'at'
  function automatic void apply_press(input logic [3:0] b, input int at);
    case (e_state)
      M_START: begin
        if (b[2]) begin
          e_state = M_CONFIRM;
          e_ref   = at;
        end else if (b[0] && b[1]) begin
          // simultaneous left/right: ignored
        end else if (b[0]) begin
          e_mode    = (e_mode == 0) ? NM - 1 : e_mode - 1;
          e_ref     = at;
          e_opt_ref = 1'b1;
        end else if (b[1]) begin
          e_mode    = (e_mode == NM - 1) ? 0 : e_mode + 1;
          e_ref     = at;
          e_opt_ref = 1'b1;
        end
      end
      default: begin
        if (b[3]) begin
          e_state   = M_START;
          e_ref     = at;
          e_opt_ref = 1'b1;
        end
      end
    endcase
  endfunction

  // Advance one edge: push the expectation, then pop and compare after the edge
  task automatic step_auto(input logic [3:0] eff);
    exp_t e;
    exp_t exp_rec;
    k++;
    if (eff != N) apply_press(eff, k);
    if (e_state == M_CONFIRM && (k - e_ref) == CT * Q) begin
      e_state = M_RUN;
      e_ref   = k;
    end
    e.k    = k;
    e.mode = 2'(e_mode);
    case (e_state)
      M_START: begin
        e.opt  = e_opt_ref ^ ((((k - e_ref) / BLINK) % 2) != 0);
        e.page = 2'd0;
        e.sp   = 1'b0;
      end
      M_CONFIRM: begin
        e.opt  = 1'b1 ^ ((((k - e_ref) / Q) % 2) != 0);
        e.page = 2'd0;
        e.sp   = 1'b0;
      end
      default: begin
        e.opt  = 1'b0;
        e.page = 2'd1;
        e.sp   = (k == e_ref);
      end
    endcase
    sbq.push_back(e);
    @(posedge clk);
    #1;
    exp_rec = sbq.pop_front();
    n_tests++;
    if ({opt, mode, page, sp} !== {exp_rec.opt, exp_rec.mode, exp_rec.page, exp_rec.sp}) begin
      n_fail++;
      $display("FAIL step k=%0d: got opt=%b mode=%0d page=%0d start_pulse=%b, expected opt=%b mode=%0d page=%0d start_pulse=%b",
               exp_rec.k, opt, mode, page, sp, exp_rec.opt, exp_rec.mode, exp_rec.page, exp_rec.sp);
    end
  endtask

  // Button a held for steps 1..ha, button b for steps sb+1..sb+hb
  task automatic run_pattern(input logic [3:0] a, input int ha, input logic [3:0] b,
                             input int sb, input int hb, input int total);
    logic [3:0] v;
    logic [3:0] eff;
    for (int i = 1; i <= total; i++) begin
      v = ((i <= ha) ? a : N) | ((i > sb && i <= sb + hb) ? b : N);
      drive(v);
      eff = N;
      if (ha >= DEB && i == EFF) eff = eff | a;
      if (hb >= DEB && i == sb + EFF) eff = eff | b;
      step_auto(eff);
    end
    drive(N);
  endtask

  task automatic check_reset(input string tag);
    n_tests++;
    if ({opt, mode, page, sp} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s: got opt=%b mode=%0d page=%0d start_pulse=%b, expected all 0",
               tag, opt, mode, page, sp);
    end else begin
      $display("[TB] %s: outputs cleared", tag);
    end
  endtask

  // Assert reset between edges, check asynchronous clear, then release
  task automatic apply_reset(input string tag);
    drive(N);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sbq.delete();
  endtask

  initial begin
    tbl[0]  = '{R,     3,  N, 0,  0, 12, 0, 0, "right_glitch"};
    tbl[1]  = '{R,     20, N, 0,  0, 28, 1, 0, "right_hold"};
    tbl[2]  = '{R,     8,  N, 0,  0, 16, 0, 0, "right_wrap"};
    tbl[3]  = '{L,     8,  N, 0,  0, 16, 1, 0, "left_wrap"};
    tbl[4]  = '{L | R, 8,  N, 0,  0, 16, 1, 0, "left_right_same"};
    tbl[5]  = '{B,     8,  N, 0,  0, 16, 1, 0, "back_in_start"};
    tbl[6]  = '{E,     8,  N, 0,  0, 24, 1, 1, "enter_to_run"};
    tbl[7]  = '{L,     8,  N, 0,  0, 16, 1, 1, "left_in_run"};
    tbl[8]  = '{B,     8,  N, 0,  0, 16, 1, 0, "back_in_run"};
    tbl[9]  = '{E,     8,  B, 7,  8, 24, 1, 0, "back_after_3_toggles"};
    tbl[10] = '{E,     8,  B, 12, 8, 28, 1, 0, "back_vs_final_toggle"};
    tbl[11] = '{R,     8,  N, 0,  0, 16, 0, 0, "right_after_abort"};

    rst_n = 1'b0;
    drive(N);
    model_reset();
    #5;
    check_reset("power_on_reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_pattern(N, 0, N, 0, 0, 40);
    $display("[TB] idle_after_reset: 40 cycles checked");

    for (int i = 0; i < 12; i++) begin
      run_pattern(tbl[i].a, tbl[i].ha, tbl[i].b, tbl[i].sb, tbl[i].hb, tbl[i].total);
      n_tests++;
      if (int'(mode) != tbl[i].exp_mode || int'(page) != tbl[i].exp_page) begin
        n_fail++;
        $display("FAIL vec %s: got mode=%0d page=%0d, expected mode=%0d page=%0d",
                 tbl[i].name, mode, page, tbl[i].exp_mode, tbl[i].exp_page);
      end else begin
        $display("[TB] vec %s: mode=%0d page=%0d", tbl[i].name, mode, page);
      end
    end

    // Reset while confirming, then the idle behaviour must repeat exactly
    run_pattern(E, 8, N, 0, 0, 12);
    apply_reset("reset_mid_confirm");
    run_pattern(N, 0, N, 0, 0, 40);
    $display("[TB] idle_after_confirm_reset: 40 cycles checked");

    // Reset during the start_pulse cycle (last step lands on the pulse)
    run_pattern(E, 8, N, 0, 0, 8 + CT * Q);
    apply_reset("reset_during_start_pulse");
    run_pattern(N, 0, N, 0, 0, 40);
    $display("[TB] idle_after_pulse_reset: 40 cycles checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
